hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 64, is the maximum number of consecutive S_MEM_WAIT cycles before a memory timeout.
REQ-002 i_clk  in  1  is the clock; all state updates on its rising edge.
REQ-003 i_rst_n  in  1  is the reset: synchronous, active-low.
REQ-004 i_id_rs1, i_id_rs2  in  5 each  are the ID-stage source register indices.
REQ-005 i_id_rs1_used, i_id_rs2_used  in  1 each  flag that the ID instruction reads that source.
REQ-006 i_ex_rd  in  5  is the EX-stage destination index; i_ex_is_load  in  1  flags a load in EX.
REQ-007 i_ex_br_taken  in  1  flags a taken branch or jump redirect resolved in EX.
REQ-008 i_mem_req  in  1  flags a load/store in MEM; i_mem_ack  in  1  flags that the LSU/peripheral completes it this cycle.
REQ-009 o_pc_en  out  1  is the PC update enable.
REQ-010 o_sel_if_id, o_sel_id_ex, o_sel_ex_mem, o_sel_mem_wb  out  2 each  are pipeline-register controls: 00 normal, 01 stall (hold), 11 flush (zero); 10 is never driven.
REQ-011 o_mem_err  out  1  is a sticky memory-timeout flag.

Function
REQ-012 The FSM SHALL have states S_RUN, S_MEM_WAIT and S_ERR; the sel/pc_en outputs SHALL be combinational from state and inputs (Mealy), so they act at the same clock edge.
REQ-013 In S_RUN, a "freeze" SHALL apply when i_mem_req=1 and i_mem_ack=0: o_pc_en=0, IF_ID/ID_EX/EX_MEM=01, MEM_WB=11; next state S_MEM_WAIT, wait_cnt cleared to 0.
REQ-014 Otherwise, when i_ex_br_taken=1: o_pc_en=1, IF_ID=11, ID_EX=11, EX_MEM=00, MEM_WB=00.
REQ-015 Otherwise, a load-use hazard SHALL apply when i_ex_is_load=1, i_ex_rd!=0 and (rs1_used and rs1==rd, or rs2_used and rs2==rd): o_pc_en=0, IF_ID=01, ID_EX=11, others 00.
REQ-016 Otherwise, all sels SHALL be 00 and o_pc_en=1.
REQ-017 Priority SHALL be freeze > branch flush > load-use > normal; a branch coinciding with a load-use hazard flushes and does not stall.
REQ-018 In S_MEM_WAIT with i_mem_ack=0, the freeze outputs SHALL apply and wait_cnt SHALL increment; when wait_cnt==WAIT_MAX-1 the next state SHALL be S_ERR.
REQ-019 In S_MEM_WAIT with i_mem_ack=1, the outputs SHALL follow REQ-014..016 (freeze excluded) and the next state SHALL be S_RUN.
REQ-020 S_ERR SHALL set o_mem_err=1, o_pc_en=0 and all sels=01, and SHALL be left only by reset.
REQ-021 wait_cnt SHALL be $clog2(WAIT_MAX) bits and SHALL not wrap, because the transition occurs at WAIT_MAX-1.

Reset
REQ-022 While i_rst_n=0: o_pc_en=0, all sels=11, o_mem_err=0; after the next edge state=S_RUN, wait_cnt=0 and counters=0.
REQ-023 Reset asserted during S_MEM_WAIT or S_ERR SHALL abort to S_RUN with no residual stall.

Configuration
REQ-024 With HAZARD_PERF_CNT_EN defined: 32-bit outputs o_stall_cycles (+1 each non-reset cycle with o_pc_en=0) and o_flush_cnt (+1 each cycle REQ-014 applies), both saturating at 32'hFFFF_FFFF.
REQ-025 Without HAZARD_PERF_CNT_EN: these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package hazard_pkg SHALL hold the SEL_NORMAL/SEL_STALL/SEL_FLUSH constants (2'b00/2'b01/2'b11) and the state enum; the pipeline registers SHALL import the same constants.
REQ-027 The counters SHALL be one sub-module, hazard_perf_cnt, instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-028 Load-use: ex_is_load=1, ex_rd=5, rs1=5, rs1_used=1 -> pc_en=0, IF_ID=01, ID_EX=11 for exactly one cycle; with ex_rd=0 -> no stall.
REQ-029 Branch plus load-use in the same cycle -> pc_en=1, IF_ID=11, ID_EX=11, no stall.
REQ-030 Memory wait: mem_req=1, ack low for 3 cycles then high -> 3 freeze cycles, then RUN outputs on the ack cycle, then S_RUN.
REQ-031 Timeout: WAIT_MAX=4, ack never asserted -> S_ERR after 4 wait cycles, o_mem_err=1, all sels=01; the flag holds until i_rst_n=0.
REQ-032 Reset asserted during S_MEM_WAIT -> all sels=11, pc_en=0; S_RUN on release.
REQ-033 With HAZARD_PERF_CNT_EN, REQ-030 stimulus plus one branch -> o_stall_cycles=3, o_flush_cnt=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   SEL_NORMAL / SEL_STALL / SEL_FLUSH : pipeline-register control codes
//   state_e                            : hazard controller FSM states
//   ctrl_t                             : bundled pc_en + per-stage selects
//   load_use_hit()                     : load-use dependency detector
package hazard_pkg;

   localparam logic [1:0] SEL_NORMAL = 2'b00;
   localparam logic [1:0] SEL_STALL  = 2'b01;
   localparam logic [1:0] SEL_FLUSH  = 2'b11;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_ERR      = 2'd2
   } state_e;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] if_id;
      logic [1:0] id_ex;
      logic [1:0] ex_mem;
      logic [1:0] mem_wb;
   } ctrl_t;

   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   function automatic logic load_use_hit(
      input logic       ex_is_load,
      input logic [4:0] ex_rd,
      input logic [4:0] rs1,
      input logic       rs1_used,
      input logic [4:0] rs2,
      input logic       rs2_used
   );
      return ex_is_load && (ex_rd != 5'd0) &&
             ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-status inputs and pipeline-control outputs of
// the hazard controller.
//   i_id_rs1/i_id_rs2, i_id_rs*_used : ID-stage source operands
//   i_ex_rd, i_ex_is_load            : EX-stage destination / load flag
//   i_ex_br_taken                    : taken branch/jump resolved in EX
//   i_mem_req, i_mem_ack             : MEM-stage access and its completion
//   o_pc_en, o_sel_*                 : PC enable and pipeline-register controls
//   o_mem_err                        : sticky memory-timeout flag
// modport master : the pipeline side (drives status, receives controls)
// modport slave  : the hazard controller
interface hazard_ctrl_if;

   logic [4:0] i_id_rs1;
   logic [4:0] i_id_rs2;
   logic       i_id_rs1_used;
   logic       i_id_rs2_used;
   logic [4:0] i_ex_rd;
   logic       i_ex_is_load;
   logic       i_ex_br_taken;
   logic       i_mem_req;
   logic       i_mem_ack;
   logic       o_pc_en;
   logic [1:0] o_sel_if_id;
   logic [1:0] o_sel_id_ex;
   logic [1:0] o_sel_ex_mem;
   logic [1:0] o_sel_mem_wb;
   logic       o_mem_err;

   modport master (
      output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
      output i_ex_rd, i_ex_is_load, i_ex_br_taken, i_mem_req, i_mem_ack,
      input  o_pc_en, o_sel_if_id, o_sel_id_ex, o_sel_ex_mem, o_sel_mem_wb,
      input  o_mem_err
   );

   modport slave (
      input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
      input  i_ex_rd, i_ex_is_load, i_ex_br_taken, i_mem_req, i_mem_ack,
      output o_pc_en, o_sel_if_id, o_sel_id_ex, o_sel_ex_mem, o_sel_mem_wb,
      output o_mem_err
   );

endinterface

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating performance counters for the hazard controller.
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_stall          : PC held this cycle
//   i_flush          : branch flush applied this cycle
//   o_stall_cycles   : cycles with the PC held (saturates at all-ones)
//   o_flush_cnt      : branch flushes (saturates at all-ones)
module hazard_perf_cnt (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic [31:0] o_stall_cycles,
   output logic [31:0] o_flush_cnt
);

   logic [31:0] stall_q, stall_d;
   logic [31:0] flush_q, flush_d;

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (i_stall && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (i_flush && (flush_q != '1)) flush_d = flush_q + 32'd1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign o_stall_cycles = stall_q;
   assign o_flush_cnt    = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (memory freeze, branch flush,
// load-use stall, memory timeout).
//   WAIT_MAX          : consecutive S_MEM_WAIT cycles before timeout
//   i_clk, i_rst_n    : clock, synchronous active-low reset
//   bus (slave)       : pipeline status in, pc_en / sel_* / mem_err out
//   o_stall_cycles,
//   o_flush_cnt       : performance counters, present only when the
//                       HAZARD_PERF_CNT_EN macro is defined
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 64
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   hazard_ctrl_if.slave       bus
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]        o_stall_cycles,
   output logic [31:0]        o_flush_cnt
`endif
);

   localparam int unsigned    CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam ctrl_t CTRL_RESET  = '{1'b0, SEL_FLUSH,  SEL_FLUSH,  SEL_FLUSH,  SEL_FLUSH};
   localparam ctrl_t CTRL_FREEZE = '{1'b0, SEL_STALL,  SEL_STALL,  SEL_STALL,  SEL_FLUSH};
   localparam ctrl_t CTRL_BRANCH = '{1'b1, SEL_FLUSH,  SEL_FLUSH,  SEL_NORMAL, SEL_NORMAL};
   localparam ctrl_t CTRL_LDUSE  = '{1'b0, SEL_STALL,  SEL_FLUSH,  SEL_NORMAL, SEL_NORMAL};
   localparam ctrl_t CTRL_NORMAL = '{1'b1, SEL_NORMAL, SEL_NORMAL, SEL_NORMAL, SEL_NORMAL};
   localparam ctrl_t CTRL_ERR    = '{1'b0, SEL_STALL,  SEL_STALL,  SEL_STALL,  SEL_STALL};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             ld_use;
   logic             mem_stall;
   logic             flush_hit;
   ctrl_t            ctrl;

   assign ld_use = load_use_hit(bus.i_ex_is_load, bus.i_ex_rd,
                                bus.i_id_rs1, bus.i_id_rs1_used,
                                bus.i_id_rs2, bus.i_id_rs2_used);
   assign mem_stall = bus.i_mem_req && !bus.i_mem_ack;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= S_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state logic; the counter stops at CNT_LAST so it never wraps.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         S_RUN: begin
            if (mem_stall) begin
               state_d    = S_MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         S_MEM_WAIT: begin
            if (bus.i_mem_ack) begin
               state_d    = S_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == CNT_LAST) begin
               state_d = S_ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_ONE;
            end
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_RUN;
      endcase
   end

   // Mealy outputs. Reset overrides everything so no stale stall survives it.
   always_comb begin
      ctrl          = CTRL_NORMAL;
      flush_hit     = 1'b0;
      bus.o_mem_err = 1'b0;
      if (!i_rst_n) begin
         ctrl = CTRL_RESET;
      end else begin
         unique case (state_q)
            S_RUN, S_MEM_WAIT: begin
               // In S_MEM_WAIT the access is still outstanding, so only ack matters.
               if ((state_q == S_RUN) ? mem_stall : !bus.i_mem_ack) begin
                  ctrl = CTRL_FREEZE;
               end else if (bus.i_ex_br_taken) begin
                  ctrl      = CTRL_BRANCH;
                  flush_hit = 1'b1;
               end else if (ld_use) begin
                  ctrl = CTRL_LDUSE;
               end else begin
                  ctrl = CTRL_NORMAL;
               end
            end
            S_ERR: begin
               ctrl          = CTRL_ERR;
               bus.o_mem_err = 1'b1;
            end
            default: ctrl = CTRL_RESET;
         endcase
      end
   end

   assign bus.o_pc_en      = ctrl.pc_en;
   assign bus.o_sel_if_id  = ctrl.if_id;
   assign bus.o_sel_id_ex  = ctrl.id_ex;
   assign bus.o_sel_ex_mem = ctrl.ex_mem;
   assign bus.o_sel_mem_wb = ctrl.mem_wb;

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_cnt u_perf_cnt (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_stall        (!ctrl.pc_en),
      .i_flush        (flush_hit),
      .o_stall_cycles (o_stall_cycles),
      .o_flush_cnt    (o_flush_cnt)
   );
`else
   logic unused_flush;
   assign unused_flush = flush_hit;
`endif

endmodule
